// File: rtl/mem_if_pkg.sv
// Shared types and constants for the memory interface unit.
package mem_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } mem_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Replicated across the data bus to form the value returned on a read timeout.
  localparam logic READ_ERROR_BIT = 1'b0;

endpackage

// File: rtl/mfc_timeout_counter.sv
// Up-counter that bounds the ACCESS phase; flags when the count reaches TC_VALUE.
module mfc_timeout_counter #(
  parameter int WIDTH    = 8,
  parameter int TC_VALUE = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal_count
);

  localparam logic [WIDTH-1:0] TC = WIDTH'(TC_VALUE);

  logic [WIDTH-1:0] count;

  // Clear has priority so a fresh access always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal_count = (count == TC);

endmodule

// File: rtl/memory_interface_unit.sv
// Memory-stage to RAM1 handshake controller with MFC timeout.
//
//   state       | meaning
//   ST_IDLE     | waiting for Mem_Request, busy low
//   ST_ACCESS   | RAM strobes active, waiting for MFC or timeout
//   ST_COMPLETE | one-cycle Mem_Done pulse (Mem_Error on timeout)
module memory_interface_unit
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic                  Mem_Request,
  input  logic                  Mem_Write,
  input  logic [ADDR_WIDTH-1:0] Mem_Address,
  input  logic [DATA_WIDTH-1:0] Mem_Write_Data,
  output logic [DATA_WIDTH-1:0] Mem_Read_Data,
  output logic                  Mem_Done,
  output logic                  Mem_Error,
  output logic                  Mem_Busy,
  output logic [ADDR_WIDTH-1:0] RAM1_Address,
  output logic [DATA_WIDTH-1:0] RAM1_Data_In,
  output logic                  RAM1_Read_H_Write_L,
  output logic                  RAM1_Out_Enable,
  input  logic [DATA_WIDTH-1:0] RAM1_Data_Out,
  input  logic                  RAM1_MFC
);

  mem_state_t state;
  logic       write_q;
  logic       timeout_tc;

  // Counter is held clear in IDLE and runs only while the RAM is being strobed.
  mfc_timeout_counter #(
    .WIDTH   (8),
    .TC_VALUE(TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk           (Clock),
    .rst_n         (Reset_L),
    .clear         (state == ST_IDLE),
    .enable        (state == ST_ACCESS),
    .terminal_count(timeout_tc)
  );

  // Sequencer: all outputs are registered so the RAM strobes are glitch-free.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state               <= ST_IDLE;
      write_q             <= 1'b0;
      RAM1_Address        <= '0;
      RAM1_Data_In        <= '0;
      Mem_Read_Data       <= '0;
      Mem_Done            <= 1'b0;
      Mem_Error           <= 1'b0;
      Mem_Busy            <= 1'b0;
      RAM1_Read_H_Write_L <= 1'b1;
      RAM1_Out_Enable     <= 1'b0;
    end else begin
      Mem_Done  <= 1'b0;
      Mem_Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Mem_Request) begin
            write_q             <= Mem_Write;
            RAM1_Address        <= Mem_Address;
            RAM1_Data_In        <= Mem_Write_Data;
            RAM1_Out_Enable     <= ~Mem_Write;
            RAM1_Read_H_Write_L <= ~Mem_Write;
            Mem_Busy            <= 1'b1;
            state               <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // MFC is checked first so a same-cycle timeout loses to a real completion.
          if (RAM1_MFC || timeout_tc) begin
            if (RAM1_MFC) begin
              if (!write_q) begin
                Mem_Read_Data <= RAM1_Data_Out;
              end
            end else begin
              Mem_Error <= 1'b1;
              if (!write_q) begin
                Mem_Read_Data <= {DATA_WIDTH{READ_ERROR_BIT}};
              end
            end
            Mem_Done            <= 1'b1;
            RAM1_Out_Enable     <= 1'b0;
            RAM1_Read_H_Write_L <= 1'b1;
            state               <= ST_COMPLETE;
          end
        end
        ST_COMPLETE: begin
          Mem_Busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          Mem_Busy            <= 1'b0;
          RAM1_Out_Enable     <= 1'b0;
          RAM1_Read_H_Write_L <= 1'b1;
          state               <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_interface_unit.sv
// Directed plus randomized check of memory_interface_unit against a transaction-level model.
module tb_memory_interface_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int T  = 16;

  logic          Clock = 1'b0;
  logic          Reset_L = 1'b1;
  logic          Mem_Request = 1'b0;
  logic          Mem_Write = 1'b0;
  logic [AW-1:0] Mem_Address = '0;
  logic [DW-1:0] Mem_Write_Data = '0;
  logic [DW-1:0] Mem_Read_Data;
  logic          Mem_Done;
  logic          Mem_Error;
  logic          Mem_Busy;
  logic [AW-1:0] RAM1_Address;
  logic [DW-1:0] RAM1_Data_In;
  logic          RAM1_Read_H_Write_L;
  logic          RAM1_Out_Enable;
  logic [DW-1:0] RAM1_Data_Out = '0;
  logic          RAM1_MFC = 1'b0;

  int total = 0;
  int bad   = 0;

  // Model of the last value a completed read left on Mem_Read_Data.
  logic [DW-1:0] model_rd = '0;

  memory_interface_unit #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .Clock              (Clock),
    .Reset_L            (Reset_L),
    .Mem_Request        (Mem_Request),
    .Mem_Write          (Mem_Write),
    .Mem_Address        (Mem_Address),
    .Mem_Write_Data     (Mem_Write_Data),
    .Mem_Read_Data      (Mem_Read_Data),
    .Mem_Done           (Mem_Done),
    .Mem_Error          (Mem_Error),
    .Mem_Busy           (Mem_Busy),
    .RAM1_Address       (RAM1_Address),
    .RAM1_Data_In       (RAM1_Data_In),
    .RAM1_Read_H_Write_L(RAM1_Read_H_Write_L),
    .RAM1_Out_Enable    (RAM1_Out_Enable),
    .RAM1_Data_Out      (RAM1_Data_Out),
    .RAM1_MFC           (RAM1_MFC)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction. mfc_at = ACCESS-cycle index where MFC is raised, -1 for never.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] rdata, input int mfc_at);
    int  access_cycles;
    int  strobe_cycles;
    int  wrong_strobe;
    bit  done_seen;
    bit  mfc_in_time;
    int  exp_cycles;
    bit  exp_err;
    access_cycles = 0;
    strobe_cycles = 0;
    wrong_strobe  = 0;
    done_seen     = 0;
    mfc_in_time   = (mfc_at >= 0) && (mfc_at < T);
    exp_cycles    = mfc_in_time ? mfc_at + 1 : T;
    exp_err       = !mfc_in_time;

    @(negedge Clock);
    Mem_Request    = 1'b1;
    Mem_Write      = wr;
    Mem_Address    = addr;
    Mem_Write_Data = wdata;
    RAM1_MFC       = 1'b0;
    @(negedge Clock);
    Mem_Request    = 1'b0;
    Mem_Address    = $urandom;
    Mem_Write_Data = $urandom;
    for (int i = 0; i < 300; i++) begin
      if (Mem_Done) begin
        done_seen = 1;
        break;
      end
      if (Mem_Busy) begin
        access_cycles++;
        if (wr ? (RAM1_Read_H_Write_L == 1'b0) : (RAM1_Out_Enable == 1'b1)) strobe_cycles++;
        if (wr ? (RAM1_Out_Enable != 1'b0) : (RAM1_Read_H_Write_L != 1'b1)) wrong_strobe++;
      end
      RAM1_MFC      = (i == mfc_at);
      RAM1_Data_Out = (i == mfc_at) ? rdata : DW'($urandom);
      @(negedge Clock);
    end
    if (!wr && mfc_in_time) model_rd = rdata;
    else if (!wr) model_rd = '0;

    check("done_seen", 64'(done_seen), 64'd1);
    check("access_cycles", 64'(access_cycles), 64'(exp_cycles));
    check("strobe_cycles", 64'(strobe_cycles), 64'(exp_cycles));
    check("wrong_strobe", 64'(wrong_strobe), 64'd0);
    check("error", 64'(Mem_Error), 64'(exp_err));
    check("read_data", 64'(Mem_Read_Data), 64'(model_rd));
    check("ram_addr", 64'(RAM1_Address), 64'(addr));
    check("ram_din", 64'(RAM1_Data_In), 64'(wdata));
    check("strobes_off", {62'd0, RAM1_Out_Enable, RAM1_Read_H_Write_L}, 64'b01);

    // MFC in COMPLETE and the following IDLE must have no effect.
    RAM1_MFC      = 1'b1;
    RAM1_Data_Out = $urandom;
    @(negedge Clock);
    check("idle_after", {61'd0, Mem_Done, Mem_Error, Mem_Busy}, 64'd0);
    check("rd_hold", 64'(Mem_Read_Data), 64'(model_rd));
    RAM1_MFC = 1'b0;
  endtask

  initial begin
    int mfc_at;
    logic wr;

    #1 Reset_L = 1'b0;
    #2;
    check("rst_busy_done_err", {61'd0, Mem_Busy, Mem_Done, Mem_Error}, 64'd0);
    check("rst_read_data", 64'(Mem_Read_Data), 64'd0);
    check("rst_latches", {RAM1_Address, RAM1_Data_In}, 64'd0);
    check("rst_strobes", {62'd0, RAM1_Out_Enable, RAM1_Read_H_Write_L}, 64'b01);
    @(negedge Clock);
    @(negedge Clock);
    Reset_L = 1'b1;

    // Directed cases.
    do_txn(1'b0, 32'h0000_0010, 32'h1111_2222, 32'hCAFE_F00D, 0);
    do_txn(1'b1, 32'h0000_0004, 32'h1234_5678, 32'hDEAD_BEEF, 4);
    do_txn(1'b0, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 5);
    do_txn(1'b0, 32'h0000_0030, 32'h0, 32'h7777_7777, -1);
    do_txn(1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_5A5A, T - 1);
    do_txn(1'b1, 32'h0000_0050, 32'h0BAD_0BAD, 32'h0, -1);
    do_txn(1'b0, 32'h0000_0060, 32'h0, 32'h0123_4567, T);

    // Randomized transactions.
    for (int n = 0; n < 24; n++) begin
      wr     = 1'($urandom_range(0, 1));
      mfc_at = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 20));
      do_txn(wr, $urandom, $urandom, $urandom, mfc_at);
    end

    // Reset during a write access aborts it.
    @(negedge Clock);
    Mem_Request    = 1'b1;
    Mem_Write      = 1'b1;
    Mem_Address    = 32'h0000_0100;
    Mem_Write_Data = 32'hFEED_FACE;
    RAM1_MFC       = 1'b0;
    @(negedge Clock);
    Mem_Request = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check("midrst_strobe_active", 64'(RAM1_Read_H_Write_L), 64'd0);
    Reset_L = 1'b0;
    #1;
    check("midrst_strobe_off", 64'(RAM1_Read_H_Write_L), 64'd1);
    check("midrst_flags", {61'd0, Mem_Busy, Mem_Done, Mem_Error}, 64'd0);
    check("midrst_rd", 64'(Mem_Read_Data), 64'd0);
    model_rd = '0;
    @(negedge Clock);
    Reset_L = 1'b1;
    begin
      int spurious;
      spurious = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge Clock);
        if (Mem_Done || Mem_Busy) spurious++;
      end
      check("midrst_no_done", 64'(spurious), 64'd0);
    end
    do_txn(1'b0, 32'h0000_0200, 32'h0, 32'h0F0F_F0F0, 2);

    // Request held high with MFC always high: three-cycle rhythm.
    @(negedge Clock);
    Mem_Request   = 1'b1;
    Mem_Write     = 1'b0;
    Mem_Address   = 32'h0000_0300;
    RAM1_MFC      = 1'b1;
    RAM1_Data_Out = 32'h3C3C_3C3C;
    begin
      int done_err;
      int busy_err;
      done_err = 0;
      busy_err = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge Clock);
        if (Mem_Done !== (i % 3 == 1)) done_err++;
        if (Mem_Busy !== (i % 3 != 2)) busy_err++;
      end
      check("b2b_done_pattern", 64'(done_err), 64'd0);
      check("b2b_busy_pattern", 64'(busy_err), 64'd0);
      check("b2b_read_data", 64'(Mem_Read_Data), 64'h3C3C_3C3C);
    end
    Mem_Request = 1'b0;
    RAM1_MFC    = 1'b0;
    repeat (4) @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
